// File: rtl/jtpopeye_pkg.sv
// Shared types and default sizing for the Popeye ROM read responder.
package jtpopeye_pkg;

    localparam int AW_DEF          = 22;
    localparam int RFSH_PERIOD_DEF = 312;
    localparam int RFSH_MAX_DEF    = 4;

    // Responder FSM: one 32-bit request becomes two 16-bit reads; refresh is
    // a separate state so it can never split the two halves of a read.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RD_LO = 2'd1,
        ST_RD_HI = 2'd2,
        ST_RFSH  = 2'd3
    } rom_st_e;

endpackage

// File: rtl/jtpopeye_rfsh_cnt.sv
// Refresh credit bookkeeping: a free-running period counter earns one credit
// per RFSH_PERIOD cycles, the responder spends one per completed refresh.
module jtpopeye_rfsh_cnt
    import jtpopeye_pkg::*;
#(
    parameter int RFSH_PERIOD = RFSH_PERIOD_DEF,
    parameter int RFSH_MAX    = RFSH_MAX_DEF,
    localparam int CW         = $clog2(RFSH_MAX + 1),
    localparam int PW         = $clog2(RFSH_PERIOD + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          spend,
    output logic [CW-1:0] credits,
    output logic          pending,
    output logic          urgent
);

    logic [PW-1:0] per;
    logic          earn;
    logic          sat;

    assign earn    = (per == PW'(RFSH_PERIOD - 1));
    assign sat     = (credits == CW'(RFSH_MAX));
    assign pending = (credits != '0);
    assign urgent  = sat;

    // Period counter wraps every RFSH_PERIOD cycles; the wrap cycle earns.
    always_ff @(posedge clk) begin
        if (!rst_n || clear)
            per <= '0;
        else if (earn)
            per <= '0;
        else
            per <= per + 1'b1;
    end

    // Saturating credit count; a simultaneous earn and spend cancel out.
    always_ff @(posedge clk) begin
        if (!rst_n || clear)
            credits <= '0;
        else if (earn && !spend && !sat)
            credits <= credits + 1'b1;
        else if (spend && !earn && pending)
            credits <= credits - 1'b1;
    end

endmodule

// File: rtl/jtpopeye_rom_resp.sv
// Responder end of the game ROM-read handshake. Each accepted 32-bit request
// is served as two 16-bit memory reads (addr, addr+1); refresh is slotted in
// between requests, opportunistically during blanking or forced when overdue.
module jtpopeye_rom_resp
    import jtpopeye_pkg::*;
#(
    parameter int AW          = AW_DEF,
    parameter int RFSH_PERIOD = RFSH_PERIOD_DEF,
    parameter int RFSH_MAX    = RFSH_MAX_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          loop_rst,
    input  logic          downloading,
    // game side
    input  logic          sdram_req,
    input  logic [AW-1:0] sdram_addr,
    output logic          sdram_ack,
    output logic [31:0]   data_read,
    output logic          data_rdy,
    input  logic          refresh_en,
    // memory side
    output logic [AW-1:0] mem_addr,
    output logic          mem_rd,
    input  logic          mem_rdy,
    input  logic [15:0]   mem_data,
    output logic          mem_rfsh,
    input  logic          mem_rfsh_done
);

    localparam int CW = $clog2(RFSH_MAX + 1);

    rom_st_e       st, st_nx;
    logic [AW-1:0] addr;
    logic [15:0]   lo;
    logic          take, lo_ld, done, spend;
    logic [CW-1:0] credits;
    logic          pending, urgent;

    jtpopeye_rfsh_cnt #(
        .RFSH_PERIOD (RFSH_PERIOD),
        .RFSH_MAX    (RFSH_MAX)
    ) u_rfsh (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (loop_rst),
        .spend   (spend),
        .credits (credits),
        .pending (pending),
        .urgent  (urgent)
    );

    // Memory strobes decode straight from the state register, so they are
    // clean and drop the cycle after the FSM leaves a read/refresh state.
    assign mem_rd   = (st == ST_RD_LO) || (st == ST_RD_HI);
    assign mem_rfsh = (st == ST_RFSH);
    assign mem_addr = (st == ST_RD_HI) ? addr + AW'(1) : addr;

    // Next-state: download blocks everything, overdue refresh beats a new
    // request, a new request beats an opportunistic refresh. A download
    // aborts an in-flight read (the game re-requests afterwards), but a
    // refresh already issued always runs to completion.
    always_comb begin
        st_nx = st;
        take  = 1'b0;
        lo_ld = 1'b0;
        done  = 1'b0;
        spend = 1'b0;
        case (st)
            ST_IDLE: begin
                if (downloading)
                    st_nx = ST_IDLE;
                else if (urgent)
                    st_nx = ST_RFSH;
                else if (sdram_req) begin
                    take  = 1'b1;
                    st_nx = ST_RD_LO;
                end else if (refresh_en && pending)
                    st_nx = ST_RFSH;
            end
            ST_RD_LO: begin
                if (downloading)
                    st_nx = ST_IDLE;
                else if (mem_rdy) begin
                    lo_ld = 1'b1;
                    st_nx = ST_RD_HI;
                end
            end
            ST_RD_HI: begin
                if (downloading)
                    st_nx = ST_IDLE;
                else if (mem_rdy) begin
                    done  = 1'b1;
                    st_nx = ST_IDLE;
                end
            end
            ST_RFSH: begin
                if (mem_rfsh_done) begin
                    spend = 1'b1;
                    st_nx = ST_IDLE;
                end
            end
            default: st_nx = ST_IDLE;
        endcase
    end

    // State, request latch and game-side response registers.
    always_ff @(posedge clk) begin
        if (!rst_n || loop_rst) begin
            st        <= ST_IDLE;
            addr      <= '0;
            lo        <= '0;
            data_read <= '0;
            data_rdy  <= 1'b0;
            sdram_ack <= 1'b0;
        end else begin
            st        <= st_nx;
            sdram_ack <= take;
            data_rdy  <= done;
            if (take)
                addr <= sdram_addr;
            if (lo_ld)
                lo <= mem_data;
            if (done)
                data_read <= {mem_data, lo};
        end
    end

endmodule
